rc4_keystream: RTL and testbench

Parametrised RC4 keystream generator, successor to the fixed 32-bit-key RC4 core. It takes a key of 1..KEY_BYTES bytes, runs init + KSA over an internal 256x8 S-box register array, then streams PRGA bytes at one byte per cycle over a valid/ready handshake. It sits between the key-management logic and the downstream XOR/cipher datapath, which applies backpressure.

---
 rtl/rc4_keystream_if.sv | 25 ++
 rtl/rc4_keystream.sv | 209 ++++++++++++++++++++
 tb/tb_rc4_keystream.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_keystream_if.sv
// Handshake/bus bundle for rc4_keystream: key load controls and the
// keystream valid/ready output channel. The master side is the key
// manager plus downstream consumer; the slave side is the generator.
interface rc4_keystream_if #(
    parameter int KEY_BYTES = 16
);
    logic                   start;
    logic                   abort;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             key_len;
    logic                   busy;
    logic                   ks_valid;
    logic                   ks_ready;
    logic [7:0]             ks_data;

    modport master (
        output start, abort, key, key_len, ks_ready,
        input  busy, ks_valid, ks_data
    );

    modport slave (
        input  start, abort, key, key_len, ks_ready,
        output busy, ks_valid, ks_data
    );
endinterface

// File: rtl/rc4_keystream.sv
// RC4 keystream generator: init + KSA over a 256x8 register S-box, then
// one PRGA byte per cycle on a valid/ready channel with backpressure.
// Optional build macro RC4_DROP_EN: discard the first DROP_N PRGA bytes
// (RC4-drop[N]) in a DROP state before the stream is presented.
module rc4_keystream #(
    parameter int KEY_BYTES = 16,
    parameter int DROP_N    = 768
) (
    input  logic            clk,
    input  logic            rst_n,
    rc4_keystream_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
`ifdef RC4_DROP_EN
        ST_DROP,
`endif
        ST_PRGA
    } state_t;

    localparam logic [8:0] KB9 = 9'(KEY_BYTES);

    generate
        if (KEY_BYTES < 1 || KEY_BYTES > 256 || DROP_N < 0 || DROP_N > 65536) begin : g_param_check
            $error("rc4_keystream: KEY_BYTES must be 1..256 and DROP_N 0..65536");
        end
    endgenerate

    state_t                 state_reg, state_next;
    logic [7:0]             s_reg [256];
    logic [7:0]             i_reg, j_reg, kidx_reg;
    logic [8:0]             klen_reg;
    logic [8*KEY_BYTES-1:0] key_reg;
    logic                   ks_valid_reg;
    logic [7:0]             ks_data_reg;
`ifdef RC4_DROP_EN
    localparam logic [15:0] DROP_LAST = 16'(DROP_N - 1);
    logic [15:0]            drop_cnt_reg;
`endif

    logic       accept_start;
    logic [8:0] eff_len;
    logic [7:0] key_byte;
    logic [7:0] ksa_j;
    logic       kidx_last;
    logic [7:0] p_i, p_j, p_si, p_sj, p_t, p_out;
    logic       prga_adv;

    assign accept_start = (state_reg == ST_IDLE) && bus.start && !bus.abort;
    assign eff_len      = (bus.key_len == 8'd0 || {1'b0, bus.key_len} > KB9) ? KB9 : {1'b0, bus.key_len};
    assign kidx_last    = ({1'b0, kidx_reg} == (klen_reg - 9'd1));
    assign prga_adv     = !ks_valid_reg || bus.ks_ready;

    // Key byte select: plain mux over the latched key, avoids a wide shifter.
    always_comb begin
        key_byte = 8'h00;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx_reg == 8'(k)) begin
                key_byte = key_reg[8*k +: 8];
            end
        end
    end

    // KSA and PRGA index arithmetic; PRGA output forwards the swapped values
    // so the byte reflects the post-swap S-box in the same cycle.
    always_comb begin
        ksa_j = j_reg + s_reg[i_reg] + key_byte;
        p_i   = i_reg + 8'd1;
        p_si  = s_reg[p_i];
        p_j   = j_reg + p_si;
        p_sj  = s_reg[p_j];
        p_t   = p_si + p_sj;
        if (p_t == p_i) begin
            p_out = p_sj;
        end else if (p_t == p_j) begin
            p_out = p_si;
        end else begin
            p_out = s_reg[p_t];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides everything.
    always_comb begin
        state_next = state_reg;
        if (bus.abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (bus.start) state_next = ST_INIT;
                ST_INIT: if (i_reg == 8'hFF) state_next = ST_KSA;
                ST_KSA: begin
                    if (i_reg == 8'hFF) begin
`ifdef RC4_DROP_EN
                        state_next = (DROP_N == 0) ? ST_PRGA : ST_DROP;
`else
                        state_next = ST_PRGA;
`endif
                    end
                end
`ifdef RC4_DROP_EN
                ST_DROP: if (drop_cnt_reg == DROP_LAST) state_next = ST_PRGA;
`endif
                ST_PRGA: state_next = ST_PRGA;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Index, key and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_reg        <= 8'h00;
            j_reg        <= 8'h00;
            kidx_reg     <= 8'h00;
            klen_reg     <= KB9;
            key_reg      <= '0;
            ks_valid_reg <= 1'b0;
            ks_data_reg  <= 8'h00;
`ifdef RC4_DROP_EN
            drop_cnt_reg <= 16'h0000;
`endif
        end else if (bus.abort) begin
            ks_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ks_valid_reg <= 1'b0;
                    if (accept_start) begin
                        i_reg    <= 8'h00;
                        j_reg    <= 8'h00;
                        kidx_reg <= 8'h00;
                        klen_reg <= eff_len;
                        key_reg  <= bus.key;
                    end
                end
                ST_INIT: begin
                    i_reg <= i_reg + 8'd1;
                end
                ST_KSA: begin
                    i_reg    <= i_reg + 8'd1;
                    j_reg    <= (i_reg == 8'hFF) ? 8'h00 : ksa_j;
                    kidx_reg <= kidx_last ? 8'h00 : kidx_reg + 8'd1;
`ifdef RC4_DROP_EN
                    drop_cnt_reg <= 16'h0000;
`endif
                end
`ifdef RC4_DROP_EN
                ST_DROP: begin
                    i_reg        <= p_i;
                    j_reg        <= p_j;
                    drop_cnt_reg <= drop_cnt_reg + 16'd1;
                end
`endif
                ST_PRGA: begin
                    if (prga_adv) begin
                        i_reg        <= p_i;
                        j_reg        <= p_j;
                        ks_data_reg  <= p_out;
                        ks_valid_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // S-box array: not reset, every start rewrites it through INIT.
    always_ff @(posedge clk) begin
        if (!bus.abort) begin
            case (state_reg)
                ST_INIT: s_reg[i_reg] <= i_reg;
                ST_KSA: begin
                    s_reg[i_reg] <= s_reg[ksa_j];
                    s_reg[ksa_j] <= s_reg[i_reg];
                end
`ifdef RC4_DROP_EN
                ST_DROP: begin
                    s_reg[p_i] <= p_sj;
                    s_reg[p_j] <= p_si;
                end
`endif
                ST_PRGA: begin
                    if (prga_adv) begin
                        s_reg[p_i] <= p_sj;
                        s_reg[p_j] <= p_si;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.ks_valid = ks_valid_reg;
    assign bus.ks_data  = ks_data_reg;

endmodule

// File: tb/tb_rc4_keystream.sv
// Self-checking bench for rc4_keystream: known-answer vectors from a table,
// random backpressure, abort/start/reset corner sequences. Works in both
// the default build and with RC4_DROP_EN (drop of 3 bytes).
module tb_rc4_keystream;

    localparam int KB        = 8;
    localparam int KB4       = 4;
    localparam int DROP_TB_N = 3;
`ifdef RC4_DROP_EN
    localparam int DROP_TB = DROP_TB_N;
`else
    localparam int DROP_TB = 0;
`endif
    localparam int LAT = 513 + DROP_TB;

    typedef struct {
        logic [63:0] key;
        logic [7:0]  klen;
        int          n;
        logic [79:0] exp;   // byte 0 in the top byte
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rc4_keystream_if #(.KEY_BYTES(KB))  bus  ();
    rc4_keystream_if #(.KEY_BYTES(KB4)) bus4 ();

    rc4_keystream #(.KEY_BYTES(KB), .DROP_N(DROP_TB_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rc4_keystream #(.KEY_BYTES(KB4), .DROP_N(DROP_TB_N)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          sel   = 0;
    logic [7:0]  exp_q [$];
    vec_t        tbl [3];

    function automatic logic cur_valid();
        return (sel == 1) ? bus4.ks_valid : bus.ks_valid;
    endfunction

    function automatic logic [7:0] cur_data();
        return (sel == 1) ? bus4.ks_data : bus.ks_data;
    endfunction

    function automatic logic cur_busy();
        return (sel == 1) ? bus4.busy : bus.busy;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ready(input logic r);
        bus.ks_ready  = r;
        bus4.ks_ready = r;
    endtask

    // Push expected bytes [from, to) of the post-drop stream of vector v.
    task automatic push_exp(input int v, input int from, input int to);
        logic [79:0] e;
        e = tbl[v].exp;
        for (int k = from; k < to; k++) begin
            exp_q.push_back(e[79 - 8*(k + DROP_TB) -: 8]);
        end
    endtask

    task automatic pulse_start(input int s, input logic [63:0] key, input logic [7:0] klen);
        sel = s;
        if (s == 1) begin
            bus4.key = key[31:0]; bus4.key_len = klen; bus4.start = 1'b1;
        end else begin
            bus.key = key; bus.key_len = klen; bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus4.start = 1'b0;
    endtask

    task automatic pulse_abort(input string tag);
        if (sel == 1) bus4.abort = 1'b1; else bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort  = 1'b0;
        bus4.abort = 1'b0;
        check({tag, "_busy"},  {31'd0, cur_busy()},  32'd0);
        check({tag, "_valid"}, {31'd0, cur_valid()}, 32'd0);
    endtask

    // Drain the scoreboard queue from the selected DUT. lat >= 0 checks the
    // edge count (from the start edge) at which ks_valid first rises.
    task automatic run_stream(input int lat, input bit rnd);
        int         cyc;
        bit         seen;
        bit         stall;
        logic [7:0] held;
        logic       v;
        logic [7:0] d;
        logic       r;
        logic [7:0] e;
        cyc   = 0;
        seen  = (lat < 0);
        stall = 1'b0;
        held  = 8'h00;
        while (exp_q.size() > 0 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            v = cur_valid();
            d = cur_data();
            if (!seen && v) begin
                seen = 1'b1;
                check("first_valid_edge", cyc, lat);
            end else if (seen && !v) begin
                check("valid_held", {31'd0, v}, 32'd1);
            end
            if (stall) begin
                check("stall_data_stable", {24'd0, d}, {24'd0, held});
            end
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v && r) begin
                e = exp_q.pop_front();
                check("ks_byte", {24'd0, d}, {24'd0, e});
                stall = 1'b0;
            end else if (v) begin
                stall = 1'b1;
                held  = d;
            end
            set_ready(r);
        end
        if (exp_q.size() > 0) begin
            check("stream_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        // let the last accepted byte's handshake edge happen
        @(posedge clk); #1;
        set_ready(1'b0);
    endtask

    initial begin
        tbl[0] = '{key: 64'h0000_0000_0079_654B, klen: 8'd3, n: 10, exp: 80'hEB9F7781B734CA72A719};
        tbl[1] = '{key: 64'h0000_0000_696B_6957, klen: 8'd4, n: 6,  exp: 80'h6044DB6D41B700000000};
        tbl[2] = '{key: 64'h0000_7465_7263_6553, klen: 8'd6, n: 8,  exp: 80'h04D46B053CA87B590000};

        bus.start = 0;  bus.abort = 0;  bus.key = '0;  bus.key_len = 0;  bus.ks_ready = 0;
        bus4.start = 0; bus4.abort = 0; bus4.key = '0; bus4.key_len = 0; bus4.ks_ready = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   {31'd0, bus.busy},     32'd0);
        check("rst_valid",  {31'd0, bus.ks_valid}, 32'd0);
        check("rst_data",   {24'd0, bus.ks_data},  32'd0);
        check("rst4_busy",  {31'd0, bus4.busy},    32'd0);
        check("rst4_valid", {31'd0, bus4.ks_valid},32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // start and abort together in IDLE: abort wins
        bus.start = 1'b1; bus.abort = 1'b1; bus.key = tbl[0].key; bus.key_len = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        check("start_abort_idle", {31'd0, bus.busy}, 32'd0);

        // known-answer vectors, ready held high
        for (int v = 0; v < 3; v++) begin
            $display("vector %0d: key_len=%0d bytes=%0d", v, tbl[v].klen, tbl[v].n - DROP_TB);
            pulse_start(0, tbl[v].key, tbl[v].klen);
            check("busy_after_start", {31'd0, bus.busy}, 32'd1);
            push_exp(v, 0, tbl[v].n - DROP_TB);
            run_stream(LAT, 1'b0);
            pulse_abort("abort_prga");
        end

        // random backpressure
        $display("random ready: key Key");
        pulse_start(0, tbl[0].key, 8'd3);
        push_exp(0, 0, 10 - DROP_TB);
        run_stream(LAT, 1'b1);
        pulse_abort("abort_rnd");

        // start during PRGA is ignored
        $display("start during PRGA");
        pulse_start(0, tbl[0].key, 8'd3);
        push_exp(0, 0, 3);
        run_stream(LAT, 1'b0);
        pulse_start(0, tbl[2].key, 8'd6);
        check("ignored_start_busy",  {31'd0, bus.busy},     32'd1);
        check("ignored_start_valid", {31'd0, bus.ks_valid}, 32'd1);
        push_exp(0, 3, 10 - DROP_TB);
        run_stream(-1, 1'b0);
        pulse_abort("abort_after_ignored");

        // abort mid-KSA, then a fresh key
        $display("abort in KSA then Wiki");
        pulse_start(0, tbl[0].key, 8'd3);
        repeat (300) @(posedge clk);
        #1;
        check("ksa_busy", {31'd0, bus.busy}, 32'd1);
        pulse_abort("abort_ksa");
        pulse_start(0, tbl[1].key, 8'd4);
        push_exp(1, 0, 6 - DROP_TB);
        run_stream(LAT, 1'b0);
        pulse_abort("abort_wiki");

        // key_len 0 and oversize on the 4-byte instance
        $display("key_len=0 on KEY_BYTES=4");
        pulse_start(1, tbl[1].key, 8'd0);
        push_exp(1, 0, 6 - DROP_TB);
        run_stream(LAT, 1'b0);
        pulse_abort("abort_len0");
        $display("key_len=9 on KEY_BYTES=4");
        pulse_start(1, tbl[1].key, 8'd9);
        push_exp(1, 0, 6 - DROP_TB);
        run_stream(LAT, 1'b1);
        pulse_abort("abort_len9");

        // asynchronous reset between edges mid-PRGA
        $display("async reset mid-PRGA");
        pulse_start(0, tbl[0].key, 8'd3);
        push_exp(0, 0, 3);
        run_stream(LAT, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, bus.ks_valid}, 32'd0);
        check("async_rst_busy",  {31'd0, bus.busy},     32'd0);
        check("async_rst_data",  {24'd0, bus.ks_data},  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_start(0, tbl[0].key, 8'd3);
        push_exp(0, 0, 10 - DROP_TB);
        run_stream(LAT, 1'b0);
        pulse_abort("abort_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
